spi_master_seq: RTL and testbench
=================================

Name: spi_master_seq

Overview:
Transaction sequencer directly upstream of the SPI TX shift stage and RX sample stage. Sequences one SPI transfer through command, address, dummy and data phases. Per phase it drives chip select, the clock-generator enable, the bit-count load (counter/counter_upd) and the 32-bit word handshake to the shift stages. Configuration comes from the register file; write data comes from the TX FIFO.

Parameters:
- NONE_DEFAULT_CS_IDLE, 1'b1, idle level of spi_csn (active-low select).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low; one clock; all state updates on rising clk
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_cmd  in  32  command word, left-aligned (MSB sent first)
- cfg_cmd_len  in  6  command bits, 0..32
- cfg_addr  in  32  address word, left-aligned
- cfg_addr_len  in  6  address bits, 0..32
- cfg_dummy  in  16  dummy SPI clock cycles
- cfg_data_len  in  16  data bits
- cfg_rd  in  1  1 = data phase is receive, 0 = transmit
- cfg_quad  in  1  address/data phases in quad mode
- tx_edge  in  1  SPI launch-edge strobe from clock generator
- clk_en  out  1  enables clock generator
- spi_csn  out  1  chip select
- en_quad  out  1  quad select to TX/RX stages
- tx_en, rx_en  out  1  shift enables
- tx_counter, rx_counter  out  16  bit-count target
- tx_counter_upd, rx_counter_upd  out  1  one-cycle load strobes
- tx_data  out  32  word to TX stage
- tx_data_valid  out  1
- tx_data_ready  in  1  from TX stage
- tx_done, rx_done  in  1  phase-complete pulses from stages
- wdata  in  32;  wdata_valid  in  1;  wdata_ready  out  1  (TX FIFO side)
- busy  out  1;  eot  out  1  one-cycle end-of-transfer pulse

Behaviour:
- Reset values: spi_csn=NONE_DEFAULT_CS_IDLE, every other output 0, FSM in IDLE, config latches 0.
- FSM: IDLE, CMD, ADDR, DUMMY, DATA_TX, DATA_RX, EOT.
- IDLE: on start, latch all cfg_* inputs. Next state = first phase with nonzero length, in order CMD, ADDR, DUMMY, DATA.
  - If all lengths are 0: go to EOT. spi_csn stays high.
  - start while not IDLE is ignored.
- busy=1 in every state except IDLE.
- spi_csn=0 and clk_en=1 in CMD, ADDR, DUMMY, DATA_*.
- Phase entry cycle (first cycle in state): pulse the phase's counter_upd for exactly one cycle.
  - TX phases: tx_counter = phase length in bits. Quad scaling is done by the TX stage.
  - RX phase: rx_counter = cfg_data_len.
  - tx_en / rx_en asserted from the entry cycle until the cycle the matching done is seen.
- en_quad: 0 in CMD (command is always single-line); cfg_quad in ADDR and DATA_*.
- CMD / ADDR word handshake:
  - tx_data = latched word; tx_data_valid=1 from entry until tx_data_ready.
  - Exactly one word per phase; tx_data_valid=0 after acceptance.
- DATA_TX: tx_data=wdata, tx_data_valid=wdata_valid, wdata_ready=tx_data_ready (combinational passthrough). wdata_ready=0 in all other states.
- FIFO underflow is not stalled: the TX stage shifts zeros. Software must prefill the FIFO.
- Phase exit: on tx_done (CMD, ADDR, DATA_TX) or rx_done (DATA_RX), move to the next nonzero phase, else EOT.
  - A done seen in the entry cycle is not possible; it is ignored.
- DUMMY: 16-bit counter cleared on entry; increments on each tx_edge. Exit on tx_edge when count==cfg_dummy-1. No tx_en, no data.
- EOT: spi_csn high, clk_en 0, eot=1 for one cycle, then IDLE.
- Length rules: lengths of 32 are legal; cfg_cmd_len>32 is clamped to 32. In quad mode, lengths not a multiple of 4 are undefined.
- Reset mid-transfer: next clock returns everything to reset values. spi_csn rises and no eot is generated.
- tx_edge coincident with phase change: belongs to the old phase. The dummy counter starts at the first edge after entry.

Optional Feature:
SPI_SEQ_ABORT_EN
- Defined: adds input abort (1 bit). abort in any non-IDLE state goes to EOT on the next clock. All enables and valids drop that clock; counter_upd is not pulsed. Abort in IDLE or EOT is ignored.
- Undefined: no port; transfers always run to completion.

Test Plan:
- cmd=0x9F000000, cmd_len=8, all others 0 → one tx_counter_upd with tx_counter=8; 8 tx_edges; tx_done → EOT; eot pulse; spi_csn low only during CMD.
- cmd_len=8, addr_len=24, dummy=8, data_len=32, rd=1, quad=1 → en_quad 0,1,x,1 per phase; rx_counter_upd with 32; exactly 8 dummy edges counted; single eot.
- Write, data_len=64, FIFO holds 0xDEADBEEF and 0xCAFEF00D → two wdata_ready handshakes; wdata_ready=0 outside DATA_TX.
- All lengths 0 + start → eot on the second cycle; spi_csn never low; busy high for one cycle.
- start while busy, and start coincident with EOT → ignored; exactly one transfer.
- rstn low during ADDR → after the reset edge spi_csn=1, busy=0, no eot. With SPI_SEQ_ABORT_EN: abort in DUMMY → EOT next clock, eot=1.

Source files
------------

// File: rtl/spi_master_seq.sv
// spi_master_seq: sequences one SPI transfer through the command, address, dummy
// and data phases. It drives chip select, the clock-generator enable, the
// per-phase bit-count loads and the word handshake to the TX/RX shift stages.
// Optional build macro: SPI_SEQ_ABORT_EN adds an 'abort' input that ends a
// transfer early by going straight to EOT.
module spi_master_seq #(
    parameter logic NONE_DEFAULT_CS_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] cfg_cmd,
    input  logic [5:0]  cfg_cmd_len,
    input  logic [31:0] cfg_addr,
    input  logic [5:0]  cfg_addr_len,
    input  logic [15:0] cfg_dummy,
    input  logic [15:0] cfg_data_len,
    input  logic        cfg_rd,
    input  logic        cfg_quad,
    input  logic        tx_edge,
    output logic        clk_en,
    output logic        spi_csn,
    output logic        en_quad,
    output logic        tx_en,
    output logic        rx_en,
    output logic [15:0] tx_counter,
    output logic [15:0] rx_counter,
    output logic        tx_counter_upd,
    output logic        rx_counter_upd,
    output logic [31:0] tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [31:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
`ifdef SPI_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        eot
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA_TX, S_DATA_RX, S_EOT
    } state_t;

    state_t      state_q, state_n, after_cur;
    logic [31:0] cmd_q, addr_q;
    logic [5:0]  cmd_len_q, addr_len_q;
    logic [15:0] dummy_q, data_len_q, dummy_cnt_q;
    logic        rd_q, quad_q;
    logic        entry_q;      // first cycle in the current state
    logic        word_sent_q;  // CMD/ADDR word already accepted by the TX stage
    logic        abort_hit;

    // Phases are visited in fixed order; zero-length phases are skipped.
    function automatic state_t phase_after(input state_t cur, input logic [5:0] cl,
                                           input logic [5:0] al, input logic [15:0] dm,
                                           input logic [15:0] dl, input logic rd);
        state_t r;
        r = S_EOT;
        if (cur == S_IDLE && cl != '0)
            r = S_CMD;
        else if ((cur == S_IDLE || cur == S_CMD) && al != '0)
            r = S_ADDR;
        else if ((cur == S_IDLE || cur == S_CMD || cur == S_ADDR) && dm != '0)
            r = S_DUMMY;
        else if (cur != S_DATA_TX && cur != S_DATA_RX && cur != S_EOT && dl != '0)
            r = rd ? S_DATA_RX : S_DATA_TX;
        return r;
    endfunction

`ifdef SPI_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_EOT);
`else
    assign abort_hit = 1'b0;
`endif

    // State register, configuration latch, entry flag, word flag and dummy counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            cmd_len_q   <= '0;
            addr_len_q  <= '0;
            dummy_q     <= '0;
            data_len_q  <= '0;
            rd_q        <= 1'b0;
            quad_q      <= 1'b0;
            entry_q     <= 1'b0;
            word_sent_q <= 1'b0;
            dummy_cnt_q <= '0;
        end else begin
            state_q <= state_n;
            entry_q <= (state_n != state_q);
            if (state_n != state_q)
                word_sent_q <= 1'b0;
            else if ((state_q == S_CMD || state_q == S_ADDR) && tx_data_valid && tx_data_ready)
                word_sent_q <= 1'b1;
            if (state_q != S_DUMMY)
                dummy_cnt_q <= '0;
            else if (tx_edge)
                dummy_cnt_q <= dummy_cnt_q + 16'd1;
            if (state_q == S_IDLE && start) begin
                cmd_q      <= cfg_cmd;
                cmd_len_q  <= (cfg_cmd_len > 6'd32) ? 6'd32 : cfg_cmd_len;
                addr_q     <= cfg_addr;
                addr_len_q <= cfg_addr_len;
                dummy_q    <= cfg_dummy;
                data_len_q <= cfg_data_len;
                rd_q       <= cfg_rd;
                quad_q     <= cfg_quad;
            end
        end
    end

    // Next-state selection and per-phase outputs.
    always_comb begin
        after_cur      = phase_after(state_q, cmd_len_q, addr_len_q, dummy_q, data_len_q, rd_q);
        state_n        = state_q;
        clk_en         = 1'b0;
        spi_csn        = NONE_DEFAULT_CS_IDLE;
        en_quad        = 1'b0;
        tx_en          = 1'b0;
        rx_en          = 1'b0;
        tx_counter     = '0;
        rx_counter     = '0;
        tx_counter_upd = 1'b0;
        rx_counter_upd = 1'b0;
        tx_data        = '0;
        tx_data_valid  = 1'b0;
        wdata_ready    = 1'b0;
        busy           = 1'b1;
        eot            = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_n = phase_after(S_IDLE, cfg_cmd_len, cfg_addr_len, cfg_dummy,
                                          cfg_data_len, cfg_rd);
            end
            S_CMD, S_ADDR: begin
                spi_csn        = 1'b0;
                clk_en         = 1'b1;
                tx_en          = 1'b1;
                en_quad        = (state_q == S_ADDR) ? quad_q : 1'b0;
                tx_counter     = {10'd0, (state_q == S_CMD) ? cmd_len_q : addr_len_q};
                tx_counter_upd = entry_q;
                tx_data        = (state_q == S_CMD) ? cmd_q : addr_q;
                tx_data_valid  = !word_sent_q;
                if (tx_done && !entry_q)
                    state_n = after_cur;
            end
            S_DUMMY: begin
                spi_csn = 1'b0;
                clk_en  = 1'b1;
                if (tx_edge && dummy_cnt_q == dummy_q - 16'd1)
                    state_n = after_cur;
            end
            S_DATA_TX: begin
                spi_csn        = 1'b0;
                clk_en         = 1'b1;
                tx_en          = 1'b1;
                en_quad        = quad_q;
                tx_counter     = data_len_q;
                tx_counter_upd = entry_q;
                tx_data        = wdata;
                tx_data_valid  = wdata_valid;
                wdata_ready    = tx_data_ready;
                if (tx_done && !entry_q)
                    state_n = after_cur;
            end
            S_DATA_RX: begin
                spi_csn        = 1'b0;
                clk_en         = 1'b1;
                rx_en          = 1'b1;
                en_quad        = quad_q;
                rx_counter     = data_len_q;
                rx_counter_upd = entry_q;
                if (rx_done && !entry_q)
                    state_n = after_cur;
            end
            S_EOT: begin
                eot     = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides the phase outputs in its own cycle; chip select stays low until EOT.
        if (abort_hit) begin
            state_n        = S_EOT;
            clk_en         = 1'b0;
            tx_en          = 1'b0;
            rx_en          = 1'b0;
            tx_counter_upd = 1'b0;
            rx_counter_upd = 1'b0;
            tx_data_valid  = 1'b0;
            wdata_ready    = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: randomized and directed bench for spi_master_seq with a
// phase-list reference model and a per-cycle output compare.
`timescale 1ns/1ps
module tb_spi_master_seq;
    localparam int P_IDLE = 0, P_CMD = 1, P_ADDR = 2, P_DUM = 3, P_DTX = 4, P_DRX = 5, P_EOT = 6;

    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [31:0] cfg_cmd = '0, cfg_addr = '0;
    logic [5:0]  cfg_cmd_len = '0, cfg_addr_len = '0;
    logic [15:0] cfg_dummy = '0, cfg_data_len = '0;
    logic        cfg_rd = 1'b0, cfg_quad = 1'b0, tx_edge = 1'b0;
    logic        clk_en, spi_csn, en_quad, tx_en, rx_en;
    logic [15:0] tx_counter, rx_counter;
    logic        tx_counter_upd, rx_counter_upd;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready = 1'b0, tx_done = 1'b0, rx_done = 1'b0;
    logic [31:0] wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready, busy, eot;
    logic        abort = 1'b0;

    spi_master_seq #(.NONE_DEFAULT_CS_IDLE(1'b1)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_cmd(cfg_cmd), .cfg_cmd_len(cfg_cmd_len), .cfg_addr(cfg_addr),
        .cfg_addr_len(cfg_addr_len), .cfg_dummy(cfg_dummy), .cfg_data_len(cfg_data_len),
        .cfg_rd(cfg_rd), .cfg_quad(cfg_quad), .tx_edge(tx_edge),
        .clk_en(clk_en), .spi_csn(spi_csn), .en_quad(en_quad), .tx_en(tx_en), .rx_en(rx_en),
        .tx_counter(tx_counter), .rx_counter(rx_counter),
        .tx_counter_upd(tx_counter_upd), .rx_counter_upd(rx_counter_upd),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .tx_done(tx_done), .rx_done(rx_done),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
`ifdef SPI_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .eot(eot)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // ---------------- reference model: list of remaining phases ----------------
    int          m_cur = P_IDLE, m_age = 0, m_dcnt = 0;
    bit          m_wacc = 0, m_valid = 0;
    logic [31:0] m_cmd, m_addr;
    int          m_cl, m_al;
    logic [15:0] m_dummy, m_dl;
    bit          m_rd, m_quad;
    int          m_plan[$];
    logic [31:0] fifo[$];

    function automatic bit in_phase(input int p);
        return p >= P_CMD && p <= P_DRX;
    endfunction

    task go(input int p);
        m_cur = p; m_age = 0; m_wacc = 0; m_dcnt = 0;
    endtask

    task nxt();
        if (m_plan.size() > 0) go(m_plan.pop_front());
        else go(P_EOT);
    endtask

    task model_update();
        bit ab;
        ab = in_phase(m_cur) && abort;
        if (!rstn) begin
            m_valid = 1; go(P_IDLE); m_plan.delete(); fifo.delete();
        end else if (m_valid) begin
            if (m_cur == P_DTX && !ab && wdata_valid && tx_data_ready && fifo.size() > 0)
                void'(fifo.pop_front());
            if (ab) go(P_EOT);
            else case (m_cur)
                P_IDLE: if (start) begin
                    m_cmd = cfg_cmd; m_addr = cfg_addr;
                    m_cl = (cfg_cmd_len > 32) ? 32 : int'(cfg_cmd_len);
                    m_al = int'(cfg_addr_len);
                    m_dummy = cfg_dummy; m_dl = cfg_data_len; m_rd = cfg_rd; m_quad = cfg_quad;
                    m_plan.delete();
                    if (m_cl != 0) m_plan.push_back(P_CMD);
                    if (m_al != 0) m_plan.push_back(P_ADDR);
                    if (m_dummy != 0) m_plan.push_back(P_DUM);
                    if (m_dl != 0) m_plan.push_back(m_rd ? P_DRX : P_DTX);
                    nxt();
                end
                P_CMD, P_ADDR: if (tx_done && m_age > 0) nxt();
                               else begin if (tx_data_ready) m_wacc = 1; m_age++; end
                P_DTX: if (tx_done && m_age > 0) nxt(); else m_age++;
                P_DRX: if (rx_done && m_age > 0) nxt(); else m_age++;
                P_DUM: begin
                    if (tx_edge) m_dcnt++;
                    if (tx_edge && m_dcnt == int'(m_dummy)) nxt(); else m_age++;
                end
                default: go(P_IDLE);
            endcase
        end
    endtask

    always @(posedge clk) model_update();

    // ---------------- observations of the DUT for directed checks ----------------
    int          o_eot, o_csn_low, o_busy, o_txen, o_dedge;
    logic [31:0] o_quadq[$], o_cntq[$], o_datq[$], o_hsq[$];

    task clear_obs();
        o_eot = 0; o_csn_low = 0; o_busy = 0; o_txen = 0; o_dedge = 0;
        o_quadq.delete(); o_cntq.delete(); o_datq.delete(); o_hsq.delete();
    endtask

    // ---------------- per-cycle compare ----------------
    task compare_cycle();
        bit ph, ab, etx, erx, evalid;
        logic [31:0] elen, edat;
        ph  = in_phase(m_cur);
        ab  = ph && abort;
        etx = (m_cur == P_CMD || m_cur == P_ADDR || m_cur == P_DTX) && !ab;
        erx = (m_cur == P_DRX) && !ab;
        chk("busy", busy, m_cur != P_IDLE);
        chk("spi_csn", spi_csn, !ph);
        chk("clk_en", clk_en, ph && !ab);
        chk("eot", eot, m_cur == P_EOT);
        chk("tx_en", tx_en, etx);
        chk("rx_en", rx_en, erx);
        chk("tx_counter_upd", tx_counter_upd, etx && m_age == 0);
        chk("rx_counter_upd", rx_counter_upd, erx && m_age == 0);
        elen = (m_cur == P_CMD) ? m_cl : (m_cur == P_ADDR) ? m_al : m_dl;
        if (etx && m_age == 0) chk("tx_counter", tx_counter, elen);
        if (erx && m_age == 0) chk("rx_counter", rx_counter, m_dl);
        if (m_cur == P_CMD || m_cur == P_ADDR) begin
            evalid = !m_wacc && !ab; edat = (m_cur == P_CMD) ? m_cmd : m_addr;
        end else begin
            evalid = (m_cur == P_DTX) && !ab && wdata_valid; edat = wdata;
        end
        chk("tx_data_valid", tx_data_valid, evalid);
        if (evalid) chk("tx_data", tx_data, edat);
        chk("wdata_ready", wdata_ready, (m_cur == P_DTX && !ab) ? tx_data_ready : 1'b0);
        if (m_cur != P_DUM)
            chk("en_quad", en_quad, (m_cur == P_ADDR || m_cur == P_DTX || m_cur == P_DRX) ? m_quad : 1'b0);
        if (eot) o_eot++;
        if (!spi_csn) o_csn_low++;
        if (busy) o_busy++;
        if (tx_en) o_txen++;
        if (busy && !spi_csn && !tx_en && !rx_en && tx_edge) o_dedge++;
        if (tx_counter_upd) begin
            o_quadq.push_back(en_quad); o_cntq.push_back(tx_counter); o_datq.push_back(tx_data);
        end
        if (rx_counter_upd) begin
            o_quadq.push_back(en_quad); o_cntq.push_back(rx_counter); o_datq.push_back('0);
        end
        if (tx_data_valid && tx_data_ready && wdata_ready) o_hsq.push_back(tx_data);
    endtask

    always @(negedge clk) if (m_valid) compare_cycle();

    // ---------------- stimulus: stage / clock-generator emulation ----------------
    task automatic step();
        @(posedge clk);
        #1;
        start = 0; abort = 0;
        tx_edge = ($urandom % 3 == 0);
        tx_data_ready = $urandom % 2;
        tx_done = 0; rx_done = 0;
        if ((m_cur == P_CMD || m_cur == P_ADDR) && m_wacc && m_age > 0 && ($urandom % 2 == 1)) tx_done = 1;
        if (m_cur == P_DTX && fifo.size() == 0 && m_age > 0 && ($urandom % 2 == 1)) tx_done = 1;
        if (m_cur == P_DRX && m_age > 0 && ($urandom % 4 == 0)) rx_done = 1;
        wdata_valid = (fifo.size() != 0) && ($urandom % 4 != 0);
        wdata = (fifo.size() != 0) ? fifo[0] : $urandom;
    endtask

    task automatic set_cfg(input logic [31:0] c, input int cl, input logic [31:0] a, input int al,
                           input int dm, input int dl, input bit rd, input bit q);
        cfg_cmd = c; cfg_cmd_len = cl[5:0]; cfg_addr = a; cfg_addr_len = al[5:0];
        cfg_dummy = dm[15:0]; cfg_data_len = dl[15:0]; cfg_rd = rd; cfg_quad = q;
    endtask

    task automatic run_idle(input int bound, input bit extra_start, input int rst_at, input bit allow_ab);
        int n = 0;
        do begin
            step(); n++;
            if (n == rst_at) begin rstn = 0; step(); rstn = 1; end
            if (extra_start && m_cur != P_IDLE && ($urandom % 2 == 1)) start = 1;
`ifdef SPI_SEQ_ABORT_EN
            if (allow_ab && ($urandom % 30 == 0)) abort = 1;
`else
            if (allow_ab) abort = 0;
`endif
        end while (m_cur != P_IDLE && n < bound);
        chk("run_done", (m_cur == P_IDLE) && !busy, 1);
    endtask

    task automatic run_to(input int p, input int bound);
        int n = 0;
        while (m_cur != p && n < bound) begin step(); n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_obs();
        rstn = 0; repeat (3) step(); rstn = 1; step();
        chk("rst_spi_csn", spi_csn, 1); chk("rst_busy", busy, 0); chk("rst_eot", eot, 0);
        chk("rst_clk_en", clk_en, 0); chk("rst_tx_en", tx_en, 0); chk("rst_wdata_ready", wdata_ready, 0);

        // single 8-bit command
        set_cfg(32'h9F000000, 8, 0, 0, 0, 0, 0, 0); clear_obs(); start = 1;
        run_idle(300, 0, -1, 0);
        chk("t1_upd_n", o_cntq.size(), 1); chk("t1_cnt", qat(o_cntq, 0), 8);
        chk("t1_data", qat(o_datq, 0), 32'h9F000000); chk("t1_eot", o_eot, 1);
        chk("t1_csn_only_cmd", o_csn_low, o_txen);

        // quad read: cmd 8, addr 24, dummy 8, data 32
        set_cfg(32'h6B000000, 8, 32'h00123400, 24, 8, 32, 1, 1); clear_obs(); start = 1;
        run_idle(500, 0, -1, 0);
        chk("t2_upd_n", o_cntq.size(), 3);
        chk("t2_q0", qat(o_quadq, 0), 0); chk("t2_q1", qat(o_quadq, 1), 1); chk("t2_q2", qat(o_quadq, 2), 1);
        chk("t2_c1", qat(o_cntq, 1), 24); chk("t2_rxcnt", qat(o_cntq, 2), 32);
        chk("t2_dummy_edges", o_dedge, 8); chk("t2_eot", o_eot, 1);

        // 64-bit write from a two-word FIFO
        fifo.delete(); fifo.push_back(32'hDEADBEEF); fifo.push_back(32'hCAFEF00D);
        set_cfg(32'h02000000, 8, 0, 0, 0, 64, 0, 0); clear_obs(); start = 1;
        run_idle(500, 0, -1, 0);
        chk("t3_hs_n", o_hsq.size(), 2);
        chk("t3_w0", qat(o_hsq, 0), 32'hDEADBEEF); chk("t3_w1", qat(o_hsq, 1), 32'hCAFEF00D);

        // all lengths zero
        set_cfg(32'h12345678, 0, 0, 0, 0, 0, 0, 0); clear_obs(); start = 1;
        step();
        chk("t4_eot", eot, 1); chk("t4_busy", busy, 1); chk("t4_csn", spi_csn, 1);
        step();
        chk("t4_eot_off", eot, 0); chk("t4_idle", busy, 0);
        chk("t4_busy_cycles", o_busy, 1); chk("t4_csn_low", o_csn_low, 0);

        // start while busy and during EOT
        set_cfg(32'hA5000000, 8, 32'h11223344, 16, 2, 0, 0, 0); clear_obs(); start = 1;
        run_idle(500, 1, -1, 0);
        repeat (4) step();
        chk("t5_one_transfer", o_eot, 1);

        // reset during ADDR
        set_cfg(32'h03000000, 8, 32'h00ABCD00, 24, 0, 8, 1, 0); start = 1;
        run_to(P_ADDR, 300);
        chk("t6_addr_upd", {tx_counter_upd, tx_counter}, {1'b1, 16'd24});
        rstn = 0; step();
        chk("t6_csn", spi_csn, 1); chk("t6_busy", busy, 0); chk("t6_eot", eot, 0);
        rstn = 1; clear_obs(); repeat (5) step();
        chk("t6_no_eot", o_eot, 0);

`ifdef SPI_SEQ_ABORT_EN
        set_cfg(32'h0B000000, 8, 0, 0, 8, 0, 0, 0); start = 1;
        run_to(P_DUM, 300);
        abort = 1; step();
        chk("ab_eot", eot, 1); chk("ab_clk_en", clk_en, 0);
        step();
        chk("ab_idle", busy, 0);
`endif

        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            int cl, dl, rst_at;
            case ($urandom % 4)
                0: cl = 0; 1: cl = 8; 2: cl = 32; default: cl = $urandom_range(33, 63);
            endcase
            dl = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 100);
            set_cfg($urandom, cl, $urandom, ($urandom % 2 == 1) ? 8 * $urandom_range(1, 4) : 0,
                    ($urandom % 2 == 1) ? $urandom_range(1, 5) : 0, dl, $urandom % 2, $urandom % 2);
            fifo.delete();
            if (!cfg_rd) for (int w = 0; w < (dl + 31) / 32; w++) fifo.push_back($urandom);
            rst_at = ($urandom % 6 == 0) ? $urandom_range(2, 20) : -1;
            start = 1; step();
            set_cfg($urandom, $urandom % 64, $urandom, $urandom % 64, $urandom % 16, $urandom % 200, $urandom % 2, $urandom % 2);
            run_idle(3000, $urandom % 2, rst_at, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
